vdc_timing_gen: RTL and testbench

- Pixel-stream source that drives the VDC-to-VCE video interface (VD, HSYN, VSYN) at the pixel rate selected by the VCE's clock_en.
- Generates standard NTSC-like raster timing plus selectable test patterns.
- Used to bring up and verify the VCE and downstream VGA path without a full VDC.
- Sits in place of the VDC, clocked on the system clock and gated by the VCE pixel enable.

---
 rtl/vdc_timing_pkg.sv | 56 +++++
 rtl/sync_axis_counter.sv | 66 ++++++
 rtl/vdc_timing_gen.sv | 149 ++++++++++++++
 tb/tb_vdc_timing_gen.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdc_timing_pkg.sv
// -----------------------------------------------------------------------------
// vdc_timing_pkg
// Shared definitions for the VDC stand-in timing generator:
//   - pattern_t      : test-pattern selector encoding
//   - *_DEF          : default NTSC-like raster timing (341 x 262)
//   - sync_window()  : start/end of the sync-low window for one axis
//   - pattern_pixel(): palette index for an active-region pixel
// -----------------------------------------------------------------------------
package vdc_timing_pkg;

    localparam int CNT_W = 9;

    localparam int H_ACTIVE_DEF = 256;
    localparam int H_FP_DEF     = 8;
    localparam int H_SYNC_DEF   = 32;
    localparam int H_BP_DEF     = 45;
    localparam int V_ACTIVE_DEF = 240;
    localparam int V_FP_DEF     = 3;
    localparam int V_SYNC_DEF   = 3;
    localparam int V_BP_DEF     = 16;

    typedef enum logic [1:0] {
        PAT_BLANK = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_GRAD  = 2'd3
    } pattern_t;

    // Sync is low for lo <= cnt < hi (hi exclusive).
    typedef struct packed {
        logic [CNT_W-1:0] lo;
        logic [CNT_W-1:0] hi;
    } sync_win_t;

    function automatic sync_win_t sync_window(input int active, input int fp, input int sync_w);
        sync_win_t win;
        win.lo = CNT_W'(active + fp);
        win.hi = CNT_W'(active + fp + sync_w);
        return win;
    endfunction

    // Only h[7:0] and v[3] ever affect the pattern.
    function automatic logic [8:0] pattern_pixel(input pattern_t pat, input logic [7:0] h, input logic v3);
        logic [8:0] px;
        px = 9'h000;
        case (pat)
            PAT_BLANK: px = 9'h000;
            PAT_BARS:  px = {6'b000001, h[7:5]};
            PAT_CHECK: px = (h[3] ^ v3) ? 9'h001 : 9'h002;
            PAT_GRAD:  px = {1'b1, h};
            default:   px = 9'h000;
        endcase
        return px;
    endfunction

endpackage

// File: rtl/sync_axis_counter.sv
// -----------------------------------------------------------------------------
// sync_axis_counter
// One raster axis: counts 0..ACTIVE+FP+SYNC+BP-1 and decodes the active
// region and the active-low sync window from the current count.
// Ports:
//   clock, reset_N : clock, asynchronous active-low reset
//   step           : advance by one (wraps at the last position)
//   clear          : force the count to 0 (wins over step)
//   cnt            : current position
//   active         : cnt < ACTIVE
//   sync_n         : low while cnt is inside the sync window
//   wrap           : step taken at the last position (count returns to 0)
// -----------------------------------------------------------------------------
module sync_axis_counter
    import vdc_timing_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE_DEF,
    parameter int FP     = H_FP_DEF,
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BP     = H_BP_DEF
) (
    input  logic             clock,
    input  logic             reset_N,
    input  logic             step,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt,
    output logic             active,
    output logic             sync_n,
    output logic             wrap
);

    localparam int               TOTAL = ACTIVE + FP + SYNC + BP;
    localparam sync_win_t        WIN   = sync_window(ACTIVE, FP, SYNC);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT   = CNT_W'(ACTIVE);

    // The 9-bit counter cannot represent a longer axis.
    if (TOTAL > 511 || TOTAL < 1) begin : g_bad_total
        $error("sync_axis_counter: axis total %0d outside 1..511", TOTAL);
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (step) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign active = (cnt_q < ACT);
    assign sync_n = !((cnt_q >= WIN.lo) && (cnt_q < WIN.hi));
    assign wrap   = step && !clear && (cnt_q == LAST);

endmodule

// File: rtl/vdc_timing_gen.sv
// -----------------------------------------------------------------------------
// vdc_timing_gen
// Stand-in for the VDC: produces a raster (VD/HSYN/VSYN) at the VCE pixel rate
// with selectable test patterns.
// Ports:
//   clock, reset_N : system clock, asynchronous active-low reset
//   clock_en       : pixel enable from the VCE; all state advances only when high
//   enable         : run; low parks the raster at (0,0) with blank outputs
//   pattern        : test pattern, taken at frame wrap or when enable rises
//   VD             : palette index, 0 outside the active region
//   HSYN, VSYN     : active-low syncs
//   frame_start    : one-clock pulse with the output of pixel (0,0)
//   frame_count    : completed frames, wraps at 256
// All outputs are registered and present the counter position of the
// previous clock_en (one pixel of latency).
// -----------------------------------------------------------------------------
module vdc_timing_gen
    import vdc_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic       clock,
    input  logic       reset_N,
    input  logic       clock_en,
    input  logic       enable,
    input  logic [1:0] pattern,
    output logic [8:0] VD,
    output logic       HSYN,
    output logic       VSYN,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_active, h_sync_n, h_wrap;
    logic             v_active, v_sync_n, v_wrap;
    logic             h_step, axis_clear, run_start;
    pattern_t         pat_q, pat_d, pat_cur;
    logic             run_q, run_d;
    logic [8:0]       vd_q, vd_d;
    logic             hsyn_q, hsyn_d;
    logic             vsyn_q, vsyn_d;
    logic             frame_start_q, frame_start_d;
    logic [7:0]       frame_count_q, frame_count_d;

    assign h_step     = clock_en & enable;
    assign axis_clear = clock_en & ~enable;
    // First running pixel after reset or a disabled period. The counters are
    // already at (0,0) here, and the new pattern applies to this very pixel.
    assign run_start  = h_step & ~run_q;
    assign pat_cur    = run_start ? pattern_t'(pattern) : pat_q;

    sync_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clock   (clock),
        .reset_N (reset_N),
        .step    (h_step),
        .clear   (axis_clear),
        .cnt     (h_cnt),
        .active  (h_active),
        .sync_n  (h_sync_n),
        .wrap    (h_wrap)
    );

    // Vertical only moves at line wrap, so VSYN changes on line boundaries.
    sync_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clock   (clock),
        .reset_N (reset_N),
        .step    (h_wrap),
        .clear   (axis_clear),
        .cnt     (v_cnt),
        .active  (v_active),
        .sync_n  (v_sync_n),
        .wrap    (v_wrap)
    );

    always_comb begin
        vd_d          = vd_q;
        hsyn_d        = hsyn_q;
        vsyn_d        = vsyn_q;
        frame_count_d = frame_count_q;
        pat_d         = pat_q;
        run_d         = run_q;
        // Pulse lasts one system clock even when clock_en is sparse.
        frame_start_d = 1'b0;
        if (clock_en) begin
            run_d = enable;
            if (enable) begin
                vd_d          = (h_active && v_active) ? pattern_pixel(pat_cur, h_cnt[7:0], v_cnt[3]) : 9'h000;
                hsyn_d        = h_sync_n;
                vsyn_d        = v_sync_n;
                frame_start_d = (h_cnt == '0) && (v_cnt == '0);
                if (run_start || v_wrap) begin
                    pat_d = pattern_t'(pattern);
                end
                if (v_wrap) begin
                    frame_count_d = frame_count_q + 8'd1;
                end
            end else begin
                vd_d   = 9'h000;
                hsyn_d = 1'b1;
                vsyn_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            vd_q          <= 9'h000;
            hsyn_q        <= 1'b1;
            vsyn_q        <= 1'b1;
            frame_start_q <= 1'b0;
            frame_count_q <= 8'd0;
            pat_q         <= PAT_BLANK;
            run_q         <= 1'b0;
        end else begin
            vd_q          <= vd_d;
            hsyn_q        <= hsyn_d;
            vsyn_q        <= vsyn_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
            pat_q         <= pat_d;
            run_q         <= run_d;
        end
    end

    assign VD          = vd_q;
    assign HSYN        = hsyn_q;
    assign VSYN        = vsyn_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vdc_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vdc_timing_gen
// Main instance: default horizontal timing (341), shortened vertical raster
// (16+2+2+2 = 22 lines, 7502 pixels per frame). A second tiny instance
// (8 x 5 = 40 pixels per frame) exercises the 8-bit frame counter wrap.
// cur_h/cur_v track the counter position the next clock_en will present.
// -----------------------------------------------------------------------------
module tb_vdc_timing_gen;

    localparam int H_TOTAL = 341;
    localparam int V_TOTAL = 22;

    logic       clock;
    logic       reset_N;
    logic       clock_en;
    logic       enable;
    logic       enable_s;
    logic [1:0] pattern;
    logic [8:0] vd, vd_s;
    logic       hsyn, vsyn, frame_start;
    logic       hsyn_s, vsyn_s, frame_start_s;
    logic [7:0] frame_count, frame_count_s;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_h    = 0;
    int cur_v    = 0;

    vdc_timing_gen #(
        .H_ACTIVE (256), .H_FP (8), .H_SYNC (32), .H_BP (45),
        .V_ACTIVE (16),  .V_FP (2), .V_SYNC (2),  .V_BP (2)
    ) dut (
        .clock       (clock),
        .reset_N     (reset_N),
        .clock_en    (clock_en),
        .enable      (enable),
        .pattern     (pattern),
        .VD          (vd),
        .HSYN        (hsyn),
        .VSYN        (vsyn),
        .frame_start (frame_start),
        .frame_count (frame_count)
    );

    vdc_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (2), .V_FP (1), .V_SYNC (1), .V_BP (1)
    ) dut_small (
        .clock       (clock),
        .reset_N     (reset_N),
        .clock_en    (clock_en),
        .enable      (enable_s),
        .pattern     (pattern),
        .VD          (vd_s),
        .HSYN        (hsyn_s),
        .VSYN        (vsyn_s),
        .frame_start (frame_start_s),
        .frame_count (frame_count_s)
    );

    // Clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, n_checks=%0d expected completion", n_checks);
        $fatal(1, "watchdog");
    end

    // Driver tasks: inputs change at the falling edge, outputs sampled there too.
    task automatic tick(input logic ce);
        clock_en = ce;
        @(posedge clock);
        if (ce) begin
            if (enable) begin
                if (cur_h == H_TOTAL - 1) begin
                    cur_h = 0;
                    cur_v = (cur_v == V_TOTAL - 1) ? 0 : cur_v + 1;
                end else begin
                    cur_h = cur_h + 1;
                end
            end else begin
                cur_h = 0;
                cur_v = 0;
            end
        end
        @(negedge clock);
    endtask

    task automatic goto_pos(input int h, input int v);
        int guard;
        guard = 0;
        while ((cur_h != h || cur_v != v) && guard < 20000) begin
            tick(1'b1);
            guard++;
        end
    endtask

    // After this, the outputs show pixel (h,v).
    task automatic present(input int h, input int v);
        goto_pos(h, v);
        tick(1'b1);
    endtask

    task automatic async_reset_pulse();
        clock_en = 1'b0;
        #2 reset_N = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset_N = 1'b1;
        cur_h   = 0;
        cur_v   = 0;
    endtask

    task automatic test_reset();
        reset_N  = 1'b0;
        clock_en = 1'b0;
        enable   = 1'b0;
        enable_s = 1'b0;
        pattern  = 2'd0;
        repeat (3) @(negedge clock);
        n_checks++; if (vd !== 9'h000)           begin n_fail++; $display("FAIL reset_vd: got %h want 000", vd); end
        n_checks++; if (hsyn !== 1'b1)           begin n_fail++; $display("FAIL reset_hsyn: got %b want 1", hsyn); end
        n_checks++; if (vsyn !== 1'b1)           begin n_fail++; $display("FAIL reset_vsyn: got %b want 1", vsyn); end
        n_checks++; if (frame_start !== 1'b0)    begin n_fail++; $display("FAIL reset_frame_start: got %b want 0", frame_start); end
        n_checks++; if (frame_count !== 8'd0)    begin n_fail++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
        n_checks++; if (frame_count_s !== 8'd0)  begin n_fail++; $display("FAIL reset_small_frame_count: got %0d want 0", frame_count_s); end
    endtask

    // clock_en every second clock; all positions measured in clock_en units.
    task automatic test_sync_timing();
        int  fs1, fs2, hf1, hf2, hr1, vf1, vr1;
        logic prev_h, prev_v, fs_now;
        fs1 = -1; fs2 = -1; hf1 = -1; hf2 = -1; hr1 = -1; vf1 = -1; vr1 = -1;
        prev_h = 1'b1; prev_v = 1'b1;
        release_reset();
        enable  = 1'b1;
        pattern = 2'd1;
        for (int i = 0; i < 7600; i++) begin
            tick(1'b1);
            fs_now = frame_start;
            if (frame_start === 1'b1) begin
                if (fs1 < 0) fs1 = i; else if (fs2 < 0) fs2 = i;
            end
            if (prev_h === 1'b1 && hsyn === 1'b0) begin
                if (hf1 < 0) hf1 = i; else if (hf2 < 0) hf2 = i;
            end
            if (prev_h === 1'b0 && hsyn === 1'b1 && hr1 < 0) hr1 = i;
            if (prev_v === 1'b1 && vsyn === 1'b0 && vf1 < 0) vf1 = i;
            if (prev_v === 1'b0 && vsyn === 1'b1 && vr1 < 0) vr1 = i;
            prev_h = hsyn;
            prev_v = vsyn;
            tick(1'b0);
            if (fs_now === 1'b1) begin
                n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL frame_start_width: still %b one clock later, want 0", frame_start); end
            end
        end
        n_checks++; if (fs1 != 0)          begin n_fail++; $display("FAIL first_frame_start: at %0d want 0", fs1); end
        n_checks++; if (fs2 != 7502)       begin n_fail++; $display("FAIL frame_period: second pulse at %0d want 7502", fs2); end
        n_checks++; if (hf1 != 264)        begin n_fail++; $display("FAIL hsync_fall: at %0d want 264", hf1); end
        n_checks++; if (hf2 - hf1 != 341)  begin n_fail++; $display("FAIL line_period: %0d want 341", hf2 - hf1); end
        n_checks++; if (hr1 - hf1 != 32)   begin n_fail++; $display("FAIL hsync_width: %0d want 32", hr1 - hf1); end
        n_checks++; if (vf1 != 6138)       begin n_fail++; $display("FAIL vsync_fall: at %0d want 6138", vf1); end
        n_checks++; if (vr1 - vf1 != 682)  begin n_fail++; $display("FAIL vsync_width: %0d want 682", vr1 - vf1); end
        n_checks++; if (frame_count !== 8'd1) begin n_fail++; $display("FAIL frame_count_one: got %0d want 1", frame_count); end
    endtask

    task automatic test_bars();
        present(0, 2);
        n_checks++; if (vd !== 9'h008) begin n_fail++; $display("FAIL bars_h0: got %h want 008", vd); end
        present(31, 2);
        n_checks++; if (vd !== 9'h008) begin n_fail++; $display("FAIL bars_h31: got %h want 008", vd); end
        present(32, 2);
        n_checks++; if (vd !== 9'h009) begin n_fail++; $display("FAIL bars_h32: got %h want 009", vd); end
        present(255, 2);
        n_checks++; if (vd !== 9'h00F) begin n_fail++; $display("FAIL bars_h255: got %h want 00F", vd); end
        present(256, 2);
        n_checks++; if (vd !== 9'h000) begin n_fail++; $display("FAIL bars_h256_blank: got %h want 000", vd); end
    endtask

    task automatic test_pattern_switch();
        goto_pos(0, 8);
        pattern = 2'd2;
        tick(1'b1);
        n_checks++; if (vd !== 9'h008) begin n_fail++; $display("FAIL switch_same_line: got %h want 008", vd); end
        present(200, 12);
        n_checks++; if (vd !== 9'h00E) begin n_fail++; $display("FAIL switch_later_line: got %h want 00E", vd); end
        present(0, 0);
        n_checks++; if (vd !== 9'h002)        begin n_fail++; $display("FAIL check_0_0: got %h want 002", vd); end
        n_checks++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL check_frame_start: got %b want 1", frame_start); end
        n_checks++; if (frame_count !== 8'd2) begin n_fail++; $display("FAIL frame_count_two: got %0d want 2", frame_count); end
        present(8, 0);
        n_checks++; if (vd !== 9'h001) begin n_fail++; $display("FAIL check_8_0: got %h want 001", vd); end
        present(0, 8);
        n_checks++; if (vd !== 9'h001) begin n_fail++; $display("FAIL check_0_8: got %h want 001", vd); end
    endtask

    task automatic test_clock_en_hold();
        present(103, 10);
        n_checks++; if (vd !== 9'h001) begin n_fail++; $display("FAIL hold_before: got %h want 001", vd); end
        for (int i = 0; i < 50; i++) begin
            tick(1'b0);
            n_checks++; if (vd !== 9'h001 || hsyn !== 1'b1 || vsyn !== 1'b1 || frame_start !== 1'b0) begin
                n_fail++; $display("FAIL hold_outputs: clk %0d vd=%h hs=%b vs=%b fs=%b want 001 1 1 0", i, vd, hsyn, vsyn, frame_start);
            end
        end
        tick(1'b1);
        n_checks++; if (vd !== 9'h002) begin n_fail++; $display("FAIL hold_resume: got %h want 002", vd); end
        present(270, 10);
        n_checks++; if (hsyn !== 1'b0) begin n_fail++; $display("FAIL hsync_mid: got %b want 0", hsyn); end
        for (int i = 0; i < 5; i++) begin
            tick(1'b0);
            n_checks++; if (hsyn !== 1'b0) begin n_fail++; $display("FAIL hold_hsync: clk %0d got %b want 0", i, hsyn); end
        end
    endtask

    task automatic test_enable_drop();
        goto_pos(120, 12);
        n_checks++; if (vd !== 9'h001) begin n_fail++; $display("FAIL before_disable: got %h want 001", vd); end
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1);
            n_checks++; if (vd !== 9'h000 || hsyn !== 1'b1 || vsyn !== 1'b1 || frame_start !== 1'b0) begin
                n_fail++; $display("FAIL disabled_outputs: ce %0d vd=%h hs=%b vs=%b fs=%b want 000 1 1 0", i, vd, hsyn, vsyn, frame_start);
            end
        end
        n_checks++; if (frame_count !== 8'd2) begin n_fail++; $display("FAIL disabled_frame_count: got %0d want 2", frame_count); end
        pattern = 2'd3;
        enable  = 1'b1;
        tick(1'b1);
        n_checks++; if (vd !== 9'h100)        begin n_fail++; $display("FAIL reenable_vd: got %h want 100", vd); end
        n_checks++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL reenable_frame_start: got %b want 1", frame_start); end
        n_checks++; if (frame_count !== 8'd2) begin n_fail++; $display("FAIL reenable_frame_count: got %0d want 2", frame_count); end
        tick(1'b1);
        n_checks++; if (vd !== 9'h101)        begin n_fail++; $display("FAIL reenable_next: got %h want 101", vd); end
        n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reenable_pulse_end: got %b want 0", frame_start); end
    endtask

    // Small instance: 40 pixels per frame, 256 frames.
    task automatic test_frame_wrap();
        enable_s = 1'b1;
        for (int n = 1; n <= 256 * 40; n++) begin
            tick(1'b1);
            if (n == 1) begin
                n_checks++; if (frame_start_s !== 1'b1) begin n_fail++; $display("FAIL small_first_frame_start: got %b want 1", frame_start_s); end
            end
            if (n == 255 * 40) begin
                n_checks++; if (frame_count_s !== 8'd255) begin n_fail++; $display("FAIL small_count_255: got %0d want 255", frame_count_s); end
            end
            if (n == 256 * 40 - 1) begin
                n_checks++; if (frame_count_s !== 8'd255) begin n_fail++; $display("FAIL small_count_hold_255: got %0d want 255", frame_count_s); end
            end
            if (n == 256 * 40) begin
                n_checks++; if (frame_count_s !== 8'd0) begin n_fail++; $display("FAIL small_count_wrap: got %0d want 0", frame_count_s); end
            end
        end
        tick(1'b1);
        n_checks++; if (frame_start_s !== 1'b1) begin n_fail++; $display("FAIL small_wrap_frame_start: got %b want 1", frame_start_s); end
    endtask

    task automatic test_async_reset();
        present(50, 3);
        n_checks++; if (vd !== 9'h132)       begin n_fail++; $display("FAIL grad_50: got %h want 132", vd); end
        n_checks++; if (frame_count === 8'd0) begin n_fail++; $display("FAIL pre_reset_frame_count: got %0d want nonzero", frame_count); end
        async_reset_pulse();
        n_checks++; if (vd !== 9'h000)           begin n_fail++; $display("FAIL async_vd: got %h want 000", vd); end
        n_checks++; if (frame_count !== 8'd0)    begin n_fail++; $display("FAIL async_frame_count: got %0d want 0", frame_count); end
        n_checks++; if (frame_count_s !== 8'd0)  begin n_fail++; $display("FAIL async_small_count: got %0d want 0", frame_count_s); end
        release_reset();
        tick(1'b1);
        n_checks++; if (vd !== 9'h100)        begin n_fail++; $display("FAIL post_reset_vd: got %h want 100", vd); end
        n_checks++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL post_reset_frame_start: got %b want 1", frame_start); end
        present(270, 19);
        n_checks++; if (hsyn !== 1'b0 || vsyn !== 1'b0) begin n_fail++; $display("FAIL pre_reset_syncs: hs=%b vs=%b want 0 0", hsyn, vsyn); end
        async_reset_pulse();
        n_checks++; if (hsyn !== 1'b1 || vsyn !== 1'b1) begin n_fail++; $display("FAIL async_syncs: hs=%b vs=%b want 1 1", hsyn, vsyn); end
        n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL async_frame_start: got %b want 0", frame_start); end
        release_reset();
    endtask

    initial begin
        test_reset();
        test_sync_timing();
        test_bars();
        test_pattern_switch();
        test_clock_en_hold();
        test_enable_drop();
        test_frame_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
